// File: rtl/fpu_conv_h2d_seq.sv
// Packed-half to double conversion sequencer.
// One shared converter walks the requested lanes, one beat per handshake.

module FpuConvH2D (
    input  logic [15:0] half,
    output logic [63:0] dbl
);

    logic        sgn;
    logic [4:0]  expH;
    logic [9:0]  manH;
    logic [10:0] expD;

    // Rebias the exponent; zero and all-ones exponents pass straight through
    always_comb begin
        sgn  = half[15];
        expH = half[14:10];
        manH = half[9:0];
        expD = 11'd0;
        if (expH == 5'd0) begin
            expD = 11'd0;
        end else if (expH == 5'd31) begin
            expD = 11'h7FF;
        end else begin
            expD = {6'd0, expH} + 11'd1008;
        end
        dbl = {sgn, expD, manH, 42'd0};
    end

endmodule

module fpu_conv_h2d_seq #(
    parameter int TAG_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [63:0]      reqData,
    input  logic [1:0]       reqLanes,
    input  logic [TAG_W-1:0] reqTag,
    output logic             rspValid,
    input  logic             rspReady,
    output logic [63:0]      rspData,
    output logic [1:0]       rspLane,
    output logic             rspLast,
    output logic [TAG_W-1:0] rspTag,
    input  logic             flush,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } seqStateT;

    seqStateT         state;
    seqStateT         stateNext;
    logic [63:0]      dataQ;
    logic [1:0]       lanesQ;
    logic [TAG_W-1:0] tagQ;
    logic [1:0]       laneCnt;
    logic [15:0]      convIn;
    logic [63:0]      convOut;

    assign convIn   = dataQ[{laneCnt, 4'd0} +: 16];
    assign reqReady = (state == IDLE);
    assign busy     = (state != IDLE);

    FpuConvH2D uConv (
        .half (convIn),
        .dbl  (convOut)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state selection; flush overrides every other transition
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    stateNext = CONV;
                end
            end
            CONV: begin
                stateNext = HOLD;
            end
            HOLD: begin
                if (rspReady) begin
                    stateNext = rspLast ? IDLE : CONV;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (flush) begin
            stateNext = IDLE;
        end
    end

    // Request latch, lane counter and registered response beat
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dataQ    <= 64'd0;
            lanesQ   <= 2'd0;
            tagQ     <= '0;
            laneCnt  <= 2'd0;
            rspValid <= 1'b0;
            rspData  <= 64'd0;
            rspLane  <= 2'd0;
            rspLast  <= 1'b0;
            rspTag   <= '0;
        end else if (flush) begin
            dataQ    <= 64'd0;
            lanesQ   <= 2'd0;
            tagQ     <= '0;
            laneCnt  <= 2'd0;
            rspValid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (reqValid) begin
                        dataQ   <= reqData;
                        lanesQ  <= reqLanes;
                        tagQ    <= reqTag;
                        laneCnt <= 2'd0;
                    end
                end
                CONV: begin
                    rspData  <= convOut;
                    rspLane  <= laneCnt;
                    rspLast  <= (laneCnt == lanesQ);
                    rspTag   <= tagQ;
                    rspValid <= 1'b1;
                end
                HOLD: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        if (!rspLast) begin
                            laneCnt <= laneCnt + 2'd1;
                        end
                    end
                end
                default: begin
                    rspValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_conv_h2d_seq.sv
// Bench for fpu_conv_h2d_seq: transaction scoreboard plus directed vectors.
// Inputs change just after rising edges; outputs are checked on falling edges.

module tb_fpu_conv_h2d_seq;

    localparam int TW = 6;

    typedef struct {
        logic [63:0]   d;
        logic [1:0]    lane;
        logic          last;
        logic [TW-1:0] tag;
    } beatT;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic [63:0]   reqData  = 64'd0;
    logic [1:0]    reqLanes = 2'd0;
    logic [TW-1:0] reqTag   = '0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [63:0]   rspData;
    logic [1:0]    rspLane;
    logic          rspLast;
    logic [TW-1:0] rspTag;
    logic          flush    = 1'b0;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int nextAt = 0;
    int accCyc = 0;

    beatT pend[$];
    beatT seen[$];

    fpu_conv_h2d_seq #(.TAG_W(TW)) dut (
        .clock    (clock),
        .reset    (reset),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqData  (reqData),
        .reqLanes (reqLanes),
        .reqTag   (reqTag),
        .rspValid (rspValid),
        .rspReady (rspReady),
        .rspData  (rspData),
        .rspLane  (rspLane),
        .rspLast  (rspLast),
        .rspTag   (rspTag),
        .flush    (flush),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Half value computed as a real number for normals; specials are bit-mapped
    function automatic logic [63:0] h2dModel(input logic [15:0] h);
        int          e;
        int          m;
        real         v;
        logic [63:0] r;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        r = 64'd0;
        if (e == 0 || e == 31) begin
            r[63]    = h[15];
            r[62:52] = (e == 31) ? 11'h7FF : 11'h000;
            r[51:42] = h[9:0];
        end else begin
            v = 1.0 + m / 1024.0;
            for (int i = 0; i < e - 15; i++) v = v * 2.0;
            for (int i = 0; i < 15 - e; i++) v = v / 2.0;
            if (h[15]) v = -v;
            r = $realtobits(v);
        end
        return r;
    endfunction

    // Scoreboard: expected beats and when the next one is due
    always @(negedge clock) begin
        logic expV;
        beatT b;
        if (!reset) begin
            pend.delete();
            chk("rstValid", rspValid, 1'b0);
            chk("rstData", rspData, 64'd0);
            chk("rstBusy", busy, 1'b0);
        end else begin
            expV = (pend.size() != 0) && (cyc >= nextAt);
            chk("rspValid", rspValid, expV);
            chk("reqReady", reqReady, pend.size() == 0);
            chk("busy", busy, pend.size() != 0);
            if (expV) begin
                chk("rspData", rspData, pend[0].d);
                chk("rspLane", rspLane, pend[0].lane);
                chk("rspLast", rspLast, pend[0].last);
                chk("rspTag", rspTag, pend[0].tag);
            end
            if (flush) begin
                pend.delete();
            end else if (expV && rspReady) begin
                seen.push_back(pend.pop_front());
                nextAt = cyc + 2;
            end else if (pend.size() == 0 && reqValid) begin
                for (int k = 0; k <= int'(reqLanes); k++) begin
                    b.d    = h2dModel(reqData[16*k +: 16]);
                    b.lane = k[1:0];
                    b.last = (k == int'(reqLanes));
                    b.tag  = reqTag;
                    pend.push_back(b);
                end
                nextAt = cyc + 2;
            end
        end
    end

    task automatic doReq(input logic [63:0] d, input logic [1:0] l,
                         input logic [TW-1:0] t);
        int n = 0;
        @(posedge clock); #1;
        reqValid = 1'b1;
        reqData  = d;
        reqLanes = l;
        reqTag   = t;
        @(negedge clock);
        while (!reqReady && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!reqReady) timeoutFail("reqAccept");
        accCyc = cyc;
        @(posedge clock); #1;
        reqValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clock);
        while ((busy || rspValid) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (busy) timeoutFail("waitIdle");
    endtask

    task automatic takeBeat(input int hold);
        int          n = 0;
        logic [63:0] d0;
        logic [1:0]  l0;
        while (!rspValid && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (!rspValid) timeoutFail("beatWait");
        d0 = rspData;
        l0 = rspLane;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("holdValid", rspValid, 1'b1);
            chk("holdData", rspData, d0);
            chk("holdLane", rspLane, l0);
        end
        rspReady = 1'b1;
        @(posedge clock); #1;
        rspReady = 1'b0;
    endtask

    initial begin
        logic [63:0] exp4 [4];
        int          n;
        int          acc1;

        #1 reset = 1'b0;
        #2;
        chk("rstNow", rspValid, 1'b0);
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("postRstReady", reqReady, 1'b1);

        // single lane, latency N+2
        rspReady = 1'b1;
        seen.delete();
        doReq(64'h0000_0000_0000_3C00, 2'd0, 6'd5);
        @(negedge clock);
        chk("latN1", rspValid, 1'b0);
        @(negedge clock);
        chk("latN2", rspValid, 1'b1);
        waitIdle();
        chk("oneCount", seen.size(), 1);
        if (seen.size() == 1) begin
            chk("oneData", seen[0].d, 64'h3FF0000000000000);
            chk("oneLane", seen[0].lane, 2'd0);
            chk("oneLast", seen[0].last, 1'b1);
            chk("oneTag", seen[0].tag, 6'd5);
        end

        // four lanes including zero and infinity
        exp4[0] = 64'h3FF0000000000000;
        exp4[1] = 64'hC000000000000000;
        exp4[2] = 64'h0000000000000000;
        exp4[3] = 64'h7FF0000000000000;
        seen.delete();
        doReq(64'h7C00_0000_C000_3C00, 2'd3, 6'd9);
        waitIdle();
        chk("fourCount", seen.size(), 4);
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            chk("fourData", seen[i].d, exp4[i]);
            chk("fourLane", seen[i].lane, i[1:0]);
            chk("fourLast", seen[i].last, i == 3);
        end

        // max normal and a subnormal
        seen.delete();
        doReq(64'h0000_0000_0001_7BFF, 2'd1, 6'd2);
        waitIdle();
        chk("maxCount", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("maxNorm", seen[0].d, 64'h40EFFC0000000000);
            chk("subNorm", seen[1].d, 64'h0000040000000000);
        end

        // mixed signs, NaN, negative zero
        doReq(64'h8000_FC01_03FF_4248, 2'd3, 6'd33);
        waitIdle();

        // backpressure on lane 1
        rspReady = 1'b0;
        seen.delete();
        doReq(64'h4400_4200_4000_3C00, 2'd2, 6'd17);
        takeBeat(0);
        takeBeat(5);
        takeBeat(0);
        waitIdle();
        chk("bpCount", seen.size(), 3);
        for (int i = 0; i < seen.size() && i < 3; i++) begin
            chk("bpLane", seen[i].lane, i[1:0]);
        end

        // flush during lane 2 hold with a same-cycle handshake
        seen.delete();
        doReq(64'h4400_4200_4000_3C00, 2'd3, 6'd21);
        takeBeat(0);
        takeBeat(0);
        n = 0;
        while (!rspValid && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (!rspValid) timeoutFail("flushWait");
        chk("flushLane", rspLane, 2'd2);
        rspReady = 1'b1;
        flush    = 1'b1;
        @(posedge clock); #1;
        flush    = 1'b0;
        rspReady = 1'b0;
        chk("flushValid", rspValid, 1'b0);
        chk("flushReady", reqReady, 1'b1);
        chk("flushBusy", busy, 1'b0);
        repeat (5) @(negedge clock);
        chk("flushCount", seen.size(), 2);

        // back-to-back with reqValid held high
        rspReady = 1'b1;
        seen.delete();
        @(posedge clock); #1;
        reqValid = 1'b1;
        reqData  = 64'h0000_0000_C000_3C00;
        reqLanes = 2'd1;
        reqTag   = 6'd1;
        n = 0;
        @(negedge clock);
        while (!reqReady && n < 40) begin
            @(negedge clock);
            n++;
        end
        acc1 = cyc;
        @(posedge clock); #1;
        reqData  = 64'h0000_0000_0000_4000;
        reqLanes = 2'd0;
        reqTag   = 6'd2;
        n = 0;
        @(negedge clock);
        while (!reqReady && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!reqReady) timeoutFail("b2bAccept");
        chk("b2bGap", cyc - acc1, 5);
        @(posedge clock); #1;
        reqValid = 1'b0;
        waitIdle();
        chk("b2bCount", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("b2bTag", seen[2].tag, 6'd2);
            chk("b2bData", seen[2].d, 64'h4000000000000000);
        end

        // asynchronous reset while converting
        doReq(64'h4400_4200_4000_3C00, 2'd3, 6'd7);
        #2 reset = 1'b0;
        #1;
        chk("arValid", rspValid, 1'b0);
        chk("arData", rspData, 64'd0);
        chk("arLast", rspLast, 1'b0);
        chk("arTag", rspTag, 6'd0);
        chk("arBusy", busy, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("arReady", reqReady, 1'b1);
        repeat (6) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
